axil_fetch_ram: RTL and testbench

Parametrised AXI-Lite read-only slave memory serving the core instruction-fetch channel (AR/R) in simulation and FPGA SoC builds.
- Byte-addressed AR channel; internal byte-to-word address conversion.
- Configurable read wait states.
- SLVERR response for out-of-range or misaligned addresses.
- Separate preload write port that testbenches use to load program images.

---
 rtl/axil_pkg.sv | 16 +
 rtl/fetch_ram_array.sv | 27 ++
 rtl/axil_fetch_ram.sv | 122 ++++++++++++
 tb/tb_axil_fetch_ram.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite fetch RAM: response codes and FSM states.
package axil_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      READ,
      RESP
   } fetch_ram_state_t;

endpackage

// File: rtl/fetch_ram_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one synchronous
// read-first read port.
module fetch_ram_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Both updates are non-blocking, so a same-edge write to rd_idx is not seen.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/axil_fetch_ram.sv
// AXI-Lite read-only slave (AR/R only) for instruction fetch, with a side
// preload port and configurable wait states between AR and R.
module axil_fetch_ram
   import axil_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 32,
   parameter int ADDR_W       = 32,
   parameter int LATENCY      = 2,
   parameter int STRICT_ALIGN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_en,
   input  logic [$clog2(DEPTH)-1:0] write_addr,
   input  logic [DATA_W-1:0]        write_data,
   input  logic [ADDR_W-1:0]        ARADDR,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   output logic [DATA_W-1:0]        RDATA,
   output logic [1:0]               RRESP,
   output logic                     RVALID,
   input  logic                     RREADY
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

   fetch_ram_state_t  state;
   logic [3:0]        cnt;
   logic [IDX_W-1:0]  idx_q;
   logic              err_q;
   logic              arready_q;
   logic              rvalid_q;
   resp_t             rresp_q;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;

   // Any index bit beyond the array range is an error, as is a misaligned
   // address when alignment is enforced.
   function automatic logic addr_err(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] idx_full;
      logic              out_of_range;
      logic              misaligned;
      idx_full     = a >> OFF_W;
      out_of_range = (idx_full >> IDX_W) != '0;
      misaligned   = (a & OFF_MASK) != '0;
      return out_of_range || ((STRICT_ALIGN != 0) && misaligned);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         err_q     <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (arready_q && ARVALID) begin
                  arready_q <= 1'b0;
                  idx_q     <= IDX_W'(ARADDR >> OFF_W);
                  err_q     <= addr_err(ARADDR);
                  if (LATENCY == 0) begin
                     state <= READ;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(LATENCY);
                  end
               end else begin
                  arready_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt <= 4'd1)
                  state <= READ;
               else
                  cnt <= cnt - 4'd1;
            end
            READ: begin
               rvalid_q <= 1'b1;
               rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
               state    <= RESP;
            end
            RESP: begin
               if (RREADY) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Errored requests never touch the array.
   assign rd_en = (state == READ) && !err_q;

   fetch_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (write_en),
      .wr_idx  (write_addr),
      .wr_data (write_data),
      .rd_en   (rd_en),
      .rd_idx  (idx_q),
      .rd_data (rd_data)
   );

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RRESP   = rresp_q;
   assign RDATA   = (rvalid_q && !err_q) ? rd_data : '0;

endmodule

// File: tb/tb_axil_fetch_ram.sv
// Directed bench for axil_fetch_ram: three instances cover LATENCY=2 strict,
// LATENCY=2 relaxed alignment, and LATENCY=0.
module tb_axil_fetch_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] araddr;
   logic [2:0]  arvalid;
   logic        rready;
   logic        arready [3];
   logic [31:0] rdata   [3];
   logic [1:0]  rresp   [3];
   logic        rvalid  [3];

   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] exp_mem [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axil_fetch_ram #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .LATENCY(2), .STRICT_ALIGN(1)) dut (
      .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .ARADDR(araddr), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
      .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready));

   axil_fetch_ram #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .LATENCY(2), .STRICT_ALIGN(0)) dut_na (
      .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .ARADDR(araddr), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
      .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready));

   axil_fetch_ram #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .LATENCY(0), .STRICT_ALIGN(1)) dut_l0 (
      .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .ARADDR(araddr), .ARVALID(arvalid[2]), .ARREADY(arready[2]),
      .RDATA(rdata[2]), .RRESP(rresp[2]), .RVALID(rvalid[2]), .RREADY(rready));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [4:0] i, input logic [31:0] d);
      write_en   = 1'b1;
      write_addr = i;
      write_data = d;
      step();
      write_en   = 1'b0;
   endtask

   // Issues one read on instance s; returns in the first cycle RVALID is seen.
   task automatic read_txn(input int s, input logic [31:0] a, input logic rr,
                           output logic [31:0] d, output logic [1:0] r,
                           output int t_hs, output int t_rv, output bit ok);
      d = '0; r = '0; t_hs = -1; t_rv = -1; ok = 1'b0;
      araddr     = a;
      arvalid[s] = 1'b1;
      rready     = rr;
      for (int i = 0; i < 40; i++) begin
         if (arready[s]) begin
            t_hs = cyc;
            break;
         end
         step();
      end
      step();
      arvalid[s] = 1'b0;
      if (t_hs >= 0) begin
         for (int i = 0; i < 40; i++) begin
            if (rvalid[s]) begin
               t_rv = cyc;
               d    = rdata[s];
               r    = rresp[s];
               ok   = 1'b1;
               break;
            end
            step();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
      araddr = '0; arvalid = '0; rready = 1'b0;
      step();
      step();
      for (int i = 0; i < 8; i++)
         exp_mem[i] = 32'hA500_0000 | 32'(i);
      exp_mem[3] = 32'hDEAD_BEEF;
      for (int i = 0; i < 8; i++)
         write_word(5'(i), exp_mem[i]);
      for (int s = 0; s < 3; s++) begin
         nvec++;
         if (arready[s] !== 1'b0) begin nerr++; $display("FAIL reset_arready[%0d]: got %b expected 0", s, arready[s]); end
         nvec++;
         if (rvalid[s] !== 1'b0) begin nerr++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", s, rvalid[s]); end
         nvec++;
         if (rdata[s] !== 32'h0) begin nerr++; $display("FAIL reset_rdata[%0d]: got %h expected 0", s, rdata[s]); end
         nvec++;
         if (rresp[s] !== 2'b00) begin nerr++; $display("FAIL reset_rresp[%0d]: got %b expected 00", s, rresp[s]); end
      end
      rst = 1'b0;
      step();
      step();
      nvec++;
      if (arready[0] !== 1'b1) begin nerr++; $display("FAIL post_reset_arready: got %b expected 1", arready[0]); end
   endtask

   task automatic test_basic_read();
      logic [31:0] d; logic [1:0] r; int th, tr; bit ok;
      read_txn(0, 32'h0C, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok) begin nerr++; $display("FAIL basic_timeout: got no RVALID expected RVALID"); end
      nvec++;
      if (tr - th != 4) begin nerr++; $display("FAIL basic_latency: got %0d expected 4", tr - th); end
      nvec++;
      if (d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL basic_rdata: got %h expected deadbeef", d); end
      nvec++;
      if (r !== 2'b00) begin nerr++; $display("FAIL basic_rresp: got %b expected 00", r); end
      step();
      nvec++;
      if (rvalid[0] !== 1'b0 || arready[0] !== 1'b1)
         begin nerr++; $display("FAIL basic_after_beat: got rvalid=%b arready=%b expected rvalid=0 arready=1", rvalid[0], arready[0]); end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic [1:0] r; int th, tr; bit ok;
      read_txn(0, 32'h0C, 1'b0, d, r, th, tr, ok);
      nvec++;
      if (!ok || d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL bp_first_beat: got ok=%0d data=%h expected ok=1 data=deadbeef", ok, d); end
      araddr = 32'h04;
      for (int i = 0; i < 5; i++) begin
         step();
         nvec++;
         if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF || rresp[0] !== 2'b00 || arready[0] !== 1'b0)
            begin nerr++; $display("FAIL bp_hold[%0d]: got rvalid=%b data=%h resp=%b arready=%b expected 1 deadbeef 00 0",
                                   i, rvalid[0], rdata[0], rresp[0], arready[0]); end
      end
      rready = 1'b1;
      step();
      nvec++;
      if (rvalid[0] !== 1'b0 || arready[0] !== 1'b1)
         begin nerr++; $display("FAIL bp_release: got rvalid=%b arready=%b expected rvalid=0 arready=1", rvalid[0], arready[0]); end
   endtask

   task automatic test_errors();
      logic [31:0] d; logic [1:0] r; int th, tr; bit ok;
      read_txn(0, 32'h80, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok || r !== 2'b10 || d !== 32'h0) begin nerr++; $display("FAIL err_range: got ok=%0d resp=%b data=%h expected 1 10 0", ok, r, d); end
      read_txn(0, 32'hFFFF_FFF0, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok || r !== 2'b10 || d !== 32'h0) begin nerr++; $display("FAIL err_upper: got ok=%0d resp=%b data=%h expected 1 10 0", ok, r, d); end
      read_txn(0, 32'h0E, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok || r !== 2'b10 || d !== 32'h0) begin nerr++; $display("FAIL err_misalign: got ok=%0d resp=%b data=%h expected 1 10 0", ok, r, d); end
      read_txn(1, 32'h0E, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok || r !== 2'b00 || d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL relaxed_align: got ok=%0d resp=%b data=%h expected 1 00 deadbeef", ok, r, d); end
      step();
   endtask

   task automatic test_back_to_back();
      int  hs_t [8];
      int  k_ar = 0;
      int  k_r  = 0;
      bit  adv  = 1'b0;
      araddr     = 32'h0;
      arvalid[2] = 1'b1;
      rready     = 1'b1;
      for (int c = 0; c < 60 && k_r < 8; c++) begin
         if (adv) begin
            adv = 1'b0;
            if (k_ar < 8) araddr = 32'(k_ar * 4);
            else          arvalid[2] = 1'b0;
         end
         if (rvalid[2]) begin
            nvec++;
            if (rdata[2] !== exp_mem[k_r] || rresp[2] !== 2'b00)
               begin nerr++; $display("FAIL b2b_beat[%0d]: got data=%h resp=%b expected data=%h resp=00", k_r, rdata[2], rresp[2], exp_mem[k_r]); end
            k_r++;
         end
         if (arvalid[2] && arready[2]) begin
            hs_t[k_ar] = cyc;
            k_ar++;
            adv = 1'b1;
         end
         step();
      end
      arvalid[2] = 1'b0;
      nvec++;
      if (k_r != 8 || k_ar != 8) begin nerr++; $display("FAIL b2b_count: got beats=%0d accepts=%0d expected 8 8", k_r, k_ar); end
      for (int i = 1; i < 8 && i < k_ar; i++) begin
         nvec++;
         if (hs_t[i] - hs_t[i-1] != 3) begin nerr++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, hs_t[i] - hs_t[i-1]); end
      end
   endtask

   task automatic test_collision();
      logic [31:0] d; logic [1:0] r; int th, tr; bit ok;
      bit hs = 1'b0;
      araddr     = 32'h14;
      arvalid[0] = 1'b1;
      rready     = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (arready[0]) begin hs = 1'b1; break; end
         step();
      end
      nvec++;
      if (!hs) begin nerr++; $display("FAIL coll_accept: got ARREADY=0 expected ARREADY=1"); end
      step();
      arvalid[0] = 1'b0;
      araddr     = 32'h0C;
      write_en = 1'b1; write_addr = 5'd5; write_data = 32'h1111_1111;
      step();
      write_en = 1'b0;
      step();
      write_en = 1'b1; write_addr = 5'd5; write_data = 32'h2222_2222;
      step();
      write_en = 1'b0;
      exp_mem[5] = 32'h2222_2222;
      nvec++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h1111_1111 || rresp[0] !== 2'b00)
         begin nerr++; $display("FAIL coll_read_first: got rvalid=%b data=%h resp=%b expected 1 11111111 00", rvalid[0], rdata[0], rresp[0]); end
      step();
      read_txn(0, 32'h14, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok || d !== exp_mem[5] || r !== 2'b00) begin nerr++; $display("FAIL coll_new_data: got ok=%0d data=%h resp=%b expected 1 22222222 00", ok, d, r); end
      step();
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; int th, tr; bit ok;
      int seen = 0;
      bit hs   = 1'b0;
      araddr     = 32'h0C;
      arvalid[0] = 1'b1;
      rready     = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (arready[0]) begin hs = 1'b1; break; end
         step();
      end
      step();
      arvalid[0] = 1'b0;
      rst        = 1'b1;
      step();
      rst = 1'b0;
      nvec++;
      if (!hs || rvalid[0] !== 1'b0 || arready[0] !== 1'b0)
         begin nerr++; $display("FAIL rstmid_outputs: got accepted=%0d rvalid=%b arready=%b expected 1 0 0", hs, rvalid[0], arready[0]); end
      step();
      nvec++;
      if (arready[0] !== 1'b1) begin nerr++; $display("FAIL rstmid_arready: got %b expected 1", arready[0]); end
      for (int i = 0; i < 10; i++) begin
         if (rvalid[0] === 1'b1) seen++;
         step();
      end
      nvec++;
      if (seen != 0) begin nerr++; $display("FAIL rstmid_no_beat: got %0d RVALID cycles expected 0", seen); end
      read_txn(0, 32'h0C, 1'b1, d, r, th, tr, ok);
      nvec++;
      if (!ok || d !== 32'hDEAD_BEEF || r !== 2'b00) begin nerr++; $display("FAIL rstmid_retained: got ok=%0d data=%h resp=%b expected 1 deadbeef 00", ok, d, r); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_backpressure();
      test_errors();
      test_back_to_back();
      test_collision();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
